// File: rtl/alu_req_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
package alu_req_sched_pkg;

  localparam int unsigned ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; ptr_i names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = valid_i[0] & (~valid_i[1] | ~ptr_i);
    grant_o[1] = valid_i[1] & (~valid_i[0] | ptr_i);
  end

endmodule

// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one external combinational ALU between two requesters.
module alu_req_sched
  import alu_req_sched_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ALU_W-1:0] req0_a,
  input  logic [ALU_W-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ALU_W-1:0] req1_a,
  input  logic [ALU_W-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [ALU_W-1:0] resp_result,
  output logic             resp_carry,
  output logic             resp_zero,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [ALU_W-1:0] alu_result,
  input  logic             alu_carry,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] ExecLast = 4'(EXEC_CYCLES - 1);

  state_e           state_q;
  logic             ptr_q;
  logic [3:0]       cnt_q;
  logic [1:0]       grant;
  logic             idle;
  logic [ALU_W-1:0] sel_a;
  logic [ALU_W-1:0] sel_b;
  logic [2:0]       sel_op;

  rr_arb2 u_arb (
    .valid_i ({req1_valid, req0_valid}),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign idle       = (state_q == StIdle);
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];

  always_comb begin
    sel_a  = req0_a;
    sel_b  = req0_b;
    sel_op = req0_op;
    if (grant[1]) begin
      sel_a  = req1_a;
      sel_b  = req1_b;
      sel_op = req1_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_zero   <= 1'b0;
      op_count    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            alu_op  <= sel_op;
            resp_id <= grant[1];
            // Next tie goes to whoever lost this one.
            ptr_q   <= grant[0];
            cnt_q   <= '0;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q == ExecLast) begin
            resp_result <= alu_result;
            resp_carry  <= alu_carry;
            resp_zero   <= (alu_result == '0);
            resp_valid  <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_count   <= op_count + CNT_W'(1);
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench: dut_a (EXEC_CYCLES=1, CNT_W=2) and dut_c (EXEC_CYCLES=3, CNT_W=8) share stimulus.
module tb_alu_req_sched;
  import alu_req_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, resp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;

  logic       a_req0_ready, a_req1_ready, a_resp_valid, a_resp_id, a_resp_carry, a_resp_zero;
  logic [3:0] a_resp_result, a_alu_a, a_alu_b, a_alu_result;
  logic [2:0] a_alu_op;
  logic       a_alu_carry;
  logic [1:0] a_op_count;

  logic       c_req0_ready, c_req1_ready, c_resp_valid, c_resp_id, c_resp_carry, c_resp_zero;
  logic [3:0] c_resp_result, c_alu_a, c_alu_b, c_alu_result;
  logic [2:0] c_alu_op;
  logic       c_alu_carry;
  logic [7:0] c_op_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the parent's combinational ALU.
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    logic [4:0] r;
    r = 5'd0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), 4'(a - b)};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOT:  r = {1'b0, ~a};
      OP_SHL:  r = {1'b0, 4'(a << b)};
      default: r = {1'b0, 4'(a >> b)};
    endcase
    return r;
  endfunction

  assign {a_alu_carry, a_alu_result} = alu_model(a_alu_a, a_alu_b, a_alu_op);
  assign {c_alu_carry, c_alu_result} = alu_model(c_alu_a, c_alu_b, c_alu_op);

  alu_req_sched #(.EXEC_CYCLES(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_id(a_resp_id),
    .resp_result(a_resp_result), .resp_carry(a_resp_carry), .resp_zero(a_resp_zero),
    .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_op(a_alu_op),
    .alu_result(a_alu_result), .alu_carry(a_alu_carry), .op_count(a_op_count)
  );

  alu_req_sched #(.EXEC_CYCLES(3), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(c_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(c_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(c_resp_valid), .resp_ready(resp_ready), .resp_id(c_resp_id),
    .resp_result(c_resp_result), .resp_carry(c_resp_carry), .resp_zero(c_resp_zero),
    .alu_a(c_alu_a), .alu_b(c_alu_b), .alu_op(c_alu_op),
    .alu_result(c_alu_result), .alu_carry(c_alu_carry), .op_count(c_op_count)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op);
    bit got;
    got = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (id ? a_req1_ready : a_req0_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) check_eq("grant_timeout", 16'd0, 16'd1);
    @(negedge clk);
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!a_resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!a_resp_valid) check_eq("resp_timeout", 16'd0, 16'd1);
  endtask

  task automatic expect_resp(input string tag, input logic id, input logic [3:0] res,
                             input logic cy, input logic z);
    check_eq({tag, "_valid"}, a_resp_valid, 1'b1);
    check_eq({tag, "_id"}, a_resp_id, id);
    check_eq({tag, "_result"}, a_resp_result, res);
    check_eq({tag, "_carry"}, a_resp_carry, cy);
    check_eq({tag, "_zero"}, a_resp_zero, z);
  endtask

  task automatic complete(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt++;
    check_eq({tag, "_cnt"}, a_op_count, 16'(exp_cnt % 4));
    check_eq({tag, "_valid_clr"}, a_resp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  last;
    bit  got;
    bit  seen;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    do_reset();

    check_eq("rst_valid", a_resp_valid, 1'b0);
    check_eq("rst_cnt", a_op_count, 16'd0);
    check_eq("rst_alu", {a_alu_a, a_alu_b, 1'b0, a_alu_op}, 16'd0);
    check_eq("rst_resp", {a_resp_id, a_resp_carry, a_resp_zero, a_resp_result}, 16'd0);
    check_eq("rst_ready", {a_req0_ready, a_req1_ready}, 16'd0);

    // ADD 9+8 -> 1 carry 1, response in the cycle after the single EXEC cycle
    issue(1'b0, 4'd9, 4'd8, OP_ADD);
    check_eq("add_alu_a", a_alu_a, 16'd9);
    check_eq("add_alu_b", a_alu_b, 16'd8);
    check_eq("add_exec_valid", a_resp_valid, 1'b0);
    @(negedge clk);
    expect_resp("add", 1'b0, 4'd1, 1'b1, 1'b0);
    complete("add");

    // SUB with and without borrow
    issue(1'b1, 4'd3, 4'd5, OP_SUB);
    wait_resp(lat);
    check_eq("sub_lat", 16'(lat), 16'd1);
    expect_resp("sub_b", 1'b1, 4'd14, 1'b1, 1'b0);
    complete("sub_b");
    issue(1'b1, 4'd5, 4'd3, OP_SUB);
    wait_resp(lat);
    expect_resp("sub_nb", 1'b1, 4'd2, 1'b0, 1'b0);
    complete("sub_nb");

    // Both requesters valid continuously: grants alternate, interval EXEC_CYCLES+2
    do_reset();
    resp_ready = 1'b1;
    req0_a = 4'd3; req0_b = 4'd1; req0_op = OP_SHL;
    req1_a = 4'd3; req1_b = 4'd1; req1_op = OP_SHL;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        #1;
        if (a_req0_ready | a_req1_ready) got = 1'b1;
        else @(negedge clk);
      end
      if (!got) check_eq("rr_timeout", 16'd0, 16'd1);
      check_eq("rr_grant", a_req1_ready, 16'(k % 2));
      check_eq("rr_onehot", a_req0_ready & a_req1_ready, 1'b0);
      if (k > 0) check_eq("rr_interval", 16'(cyc - last), 16'd3);
      last = cyc;
      @(negedge clk);
      wait_resp(lat);
      expect_resp("rr", 1'(k % 2), 4'd6, 1'b0, 1'b0);
      @(negedge clk);
      exp_cnt++;
      check_eq("rr_cnt", a_op_count, 16'(exp_cnt % 4));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: XOR 5^5 held for three cycles with both requesters waiting
    resp_ready = 1'b0;
    @(negedge clk);
    issue(1'b0, 4'd5, 4'd5, OP_XOR);
    wait_resp(lat);
    expect_resp("bp", 1'b0, 4'd0, 1'b0, 1'b1);
    req0_a = 4'd1; req1_a = 4'd2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      expect_resp("bp_hold", 1'b0, 4'd0, 1'b0, 1'b1);
      check_eq("bp_ready", {a_req0_ready, a_req1_ready}, 16'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check_eq("bp_cnt", a_op_count, 16'(exp_cnt % 4));
    check_eq("bp_valid_clr", a_resp_valid, 1'b0);
    #1;
    check_eq("bp_idle_grant", {a_req0_ready, a_req1_ready}, 16'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;

    // dut_c: latency with EXEC_CYCLES=3, then reset during EXEC
    do_reset();
    resp_ready = 1'b1;
    issue(1'b0, 4'd9, 4'd8, OP_ADD);
    lat = 0;
    while (!c_resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("c_lat", 16'(lat), 16'd3);
    check_eq("c_result", {c_resp_id, c_resp_carry, c_resp_zero, c_resp_result}, 16'b010_0001);
    @(negedge clk);
    check_eq("c_cnt1", c_op_count, 16'd1);
    issue(1'b0, 4'd2, 4'd2, OP_ADD);
    @(negedge clk);
    check_eq("c_exec_valid", c_resp_valid, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= c_resp_valid;
    end
    check_eq("c_no_resp", seen, 1'b0);
    check_eq("c_cnt_rst", c_op_count, 16'd0);
    check_eq("c_alu_rst", c_alu_a, 16'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_eq("c_first_grant", {c_req0_ready, c_req1_ready}, 16'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;

    // op_count wrap with CNT_W=2: 1,2,3,0,1
    do_reset();
    for (int k = 0; k < 5; k++) begin
      issue(1'b0, 4'(k), 4'd1, OP_ADD);
      wait_resp(lat);
      expect_resp("wrap", 1'b0, 4'(k + 1), 1'b0, 1'b0);
      complete("wrap");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
